// File: rtl/delay_line.sv
// Multi-lane sample delay line with a shared circular pointer and EMPTY/FILL/RUN priming.
// Define DELAY_LINE_RUNTIME_DELAY_EN to allow loading the delay at run time.
//
// state   | meaning
// S_EMPTY | flushed by reset, clear or delay load; no enabled step seen yet
// S_FILL  | counting enabled steps until the line holds cur_delay samples
// S_RUN   | delay satisfied; every enabled step emits a valid sample
module delay_line #(
  parameter int pDataLength = 16,
  parameter int pChannels   = 4,
  parameter int pMaxDelay   = 32,
  parameter int pPtrLength  = 6
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               clear,
  input  logic                               delay_load,
  input  logic [pPtrLength-1:0]              delay_in,
  input  logic [pChannels*pDataLength-1:0]   val_in,
  output logic [pChannels*pDataLength-1:0]   val_out,
  output logic                               valid_out,
  output logic                               primed,
  output logic [pPtrLength-1:0]              cur_delay
);

  localparam int cWidth = pChannels * pDataLength;
  localparam int cAddrW = (pMaxDelay > 1) ? $clog2(pMaxDelay) : 1;
  localparam logic [pPtrLength-1:0] cMaxDelay = pPtrLength'(pMaxDelay);
  localparam logic [pPtrLength-1:0] cOne      = pPtrLength'(1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [pPtrLength-1:0]   r_ptr;
  logic [pPtrLength-1:0]   r_fill;
  logic [pPtrLength-1:0]   w_fill_nxt;
  logic [pPtrLength-1:0]   w_fill_inc;
  logic [pPtrLength-1:0]   w_ptr_nxt;
  logic [pPtrLength-1:0]   w_delay;
  logic [cAddrW-1:0]       w_addr;
  logic [cWidth-1:0]       r_val_out;
  logic                    r_valid;
  logic                    w_load;
  logic                    w_flush;
  logic                    w_step;
  logic [cWidth-1:0]       r_mem [pMaxDelay];

`ifdef DELAY_LINE_RUNTIME_DELAY_EN
  logic [pPtrLength-1:0]   r_cur_delay;
  logic [pPtrLength-1:0]   w_delay_clamped;

  assign w_load = delay_load;

  always_comb begin
    w_delay_clamped = delay_in;
    if (delay_in == '0) begin
      w_delay_clamped = cOne;
    end else if (delay_in > cMaxDelay) begin
      w_delay_clamped = cMaxDelay;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_delay <= cMaxDelay;
    end else if (w_load) begin
      r_cur_delay <= w_delay_clamped;
    end
  end

  assign w_delay = r_cur_delay;
`else
  logic w_unused;

  assign w_unused = &{1'b0, delay_load, delay_in};
  assign w_load   = 1'b0;
  assign w_delay  = cMaxDelay;
`endif

  // A sample arriving with a flush is discarded, never written or counted.
  assign w_flush    = w_load | clear;
  assign w_step     = enable & ~w_flush;
  assign w_fill_inc = r_fill + cOne;
  assign w_ptr_nxt  = (r_ptr == (w_delay - cOne)) ? '0 : (r_ptr + cOne);
  assign w_addr     = r_ptr[cAddrW-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    if (w_flush) begin
      w_state_nxt = S_EMPTY;
      w_fill_nxt  = '0;
    end else if (w_step) begin
      case (r_state)
        S_EMPTY, S_FILL: begin
          w_fill_nxt  = w_fill_inc;
          w_state_nxt = (w_fill_inc == w_delay) ? S_RUN : S_FILL;
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_EMPTY;
      r_fill    <= '0;
      r_ptr     <= '0;
      r_val_out <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fill  <= w_fill_nxt;
      r_valid <= 1'b0;
      if (w_flush) begin
        r_ptr     <= '0;
        r_val_out <= '0;
      end else if (w_step) begin
        r_ptr     <= w_ptr_nxt;
        r_val_out <= (r_state == S_RUN) ? r_mem[w_addr] : '0;
        r_valid   <= (r_state == S_RUN);
      end
    end
  end

  // Storage is left uninitialised; stale entries are masked until RUN.
  always_ff @(posedge clk) begin
    if (!reset && w_step) begin
      r_mem[w_addr] <= val_in;
    end
  end

  assign val_out   = r_val_out;
  assign valid_out = r_valid;
  assign primed    = (r_state == S_RUN);
  assign cur_delay = w_delay;

endmodule

// File: tb/tb_delay_line.sv
// Scoreboard bench for delay_line: the driver pushes expected delayed samples,
// a negedge monitor pops and compares whenever valid_out is high.
module tb_delay_line;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic          delay_load = 1'b0;
  logic [5:0]    delay_in = '0;
  logic [W-1:0]  val_in = '0;
  logic [W-1:0]  val_out;
  logic          valid_out;
  logic          primed;
  logic [5:0]    cur_delay;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] hist[$];
  logic [W-1:0] exp_q[$];
  int           nsteps = 0;
  int           dly = 32;

  delay_line dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .delay_load(delay_load), .delay_in(delay_in), .val_in(val_in),
    .val_out(val_out), .valid_out(valid_out), .primed(primed),
    .cur_delay(cur_delay)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_valid", {63'd0, valid_out}, '0);
      else chk("val_out", val_out, exp_q.pop_front());
    end
  end

  function automatic int clampd(input int d);
    if (d == 0) return 1;
    if (d > 32) return 32;
    return d;
  endfunction

  task automatic model_flush();
    hist.delete();
    nsteps = 0;
  endtask

  task automatic model_advance(input logic [W-1:0] v);
    if (nsteps >= dly) exp_q.push_back(hist[nsteps - dly]);
    hist.push_back(v);
    nsteps++;
  endtask

  task automatic post_step_checks();
    chk("primed", {63'd0, primed}, {63'd0, nsteps >= dly});
    if (nsteps - 1 < dly) begin
      chk("fill_val_out", val_out, '0);
      chk("fill_valid", {63'd0, valid_out}, '0);
    end else begin
      chk("run_valid", {63'd0, valid_out}, 64'd1);
    end
  endtask

  task automatic step(input logic [W-1:0] v);
    enable = 1'b1;
    val_in = v;
    @(posedge clk); #1;
    enable = 1'b0;
    model_advance(v);
    post_step_checks();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      chk("idle_valid", {63'd0, valid_out}, '0);
    end
  endtask

  task automatic do_clear(input logic [W-1:0] v);
    clear = 1'b1; enable = 1'b1; val_in = v;
    @(posedge clk); #1;
    clear = 1'b0; enable = 1'b0;
    model_flush();
    chk("clear_primed", {63'd0, primed}, '0);
    chk("clear_val_out", val_out, '0);
    chk("clear_valid", {63'd0, valid_out}, '0);
  endtask

  task automatic do_load(input int d, input logic [W-1:0] v);
    delay_load = 1'b1; delay_in = 6'(d); enable = 1'b1; val_in = v;
    @(posedge clk); #1;
    delay_load = 1'b0; enable = 1'b0;
`ifdef DELAY_LINE_RUNTIME_DELAY_EN
    model_flush();
    dly = clampd(d);
    chk("load_val_out", val_out, '0);
    chk("load_valid", {63'd0, valid_out}, '0);
    chk("load_primed", {63'd0, primed}, '0);
`else
    model_advance(v);
    post_step_checks();
`endif
    chk("cur_delay", {58'd0, cur_delay}, 64'(dly));
  endtask

  function automatic logic [W-1:0] lanes(input int n);
    return {16'(n + 300), 16'(n + 200), 16'(n + 100), 16'(n)};
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_val_out", val_out, '0);
    chk("rst_valid", {63'd0, valid_out}, '0);
    chk("rst_primed", {63'd0, primed}, '0);
    chk("rst_cur_delay", {58'd0, cur_delay}, 64'd32);

    // 40 steps at delay 32, ch0 = step index
    for (int i = 0; i < 40; i++) step(64'(i));

    // delay 5, four independent lanes
    do_load(5, 64'hDEAD_BEEF_0BAD_F00D);
    for (int n = 1; n <= 12; n++) step(lanes(n));

    // delay 3 with enable pattern 1,0,0
    do_load(3, 64'h1234);
    for (int n = 0; n < 10; n++) begin
      step(64'(n + 500));
      idle(2);
    end

    // delay 4, reach RUN, then clear with a coinciding sample
    do_load(4, 64'h5555);
    for (int n = 0; n < 6; n++) step(64'(n + 700));
    do_clear(64'hAAAA);
    for (int n = 0; n < 7; n++) step(64'(n + 900));

    // clamping, including delay 1 behaviour
    do_load(0, 64'h7777);
    for (int n = 0; n < 3; n++) step(64'(n + 1100));
    do_load(40, 64'h8888);

    // reset in RUN together with load and enable
    for (int n = 0; n < 33; n++) step(64'(n + 1300));
    reset = 1'b1; delay_load = 1'b1; delay_in = 6'd5; enable = 1'b1; val_in = 64'hFFFF;
    @(posedge clk); #1;
    reset = 1'b0; delay_load = 1'b0; enable = 1'b0;
    model_flush();
    dly = 32;
    chk("rst2_val_out", val_out, '0);
    chk("rst2_valid", {63'd0, valid_out}, '0);
    chk("rst2_primed", {63'd0, primed}, '0);
    chk("rst2_cur_delay", {58'd0, cur_delay}, 64'd32);
    for (int n = 0; n < 34; n++) step(64'(n + 1500));

    idle(3);
    chk("exp_q_drained", 64'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_line.md
DELAY_LINE -- requirements
Module: delay_line

Interface
REQ-001 Parameter pDataLength, default 16: sample width per channel.
REQ-002 Parameter pChannels, default 4: parallel lanes sharing one pointer.
REQ-003 Parameter pMaxDelay, default 32: maximum delay in enabled steps, >= 2.
REQ-004 Parameter pPtrLength, default 6: width of pointer, fill counter and delay; SHALL be wide enough to hold the value pMaxDelay.
REQ-005 clk  input  1  the single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  advances the line by one step when high.
REQ-008 clear  input  1  synchronous flush of pointer, fill state and output.
REQ-009 delay_load  input  1  loads delay_in and flushes the line.
REQ-010 delay_in  input  pPtrLength  requested delay in steps.
REQ-011 val_in  input  pChannels*pDataLength  packed samples; channel c at bits [c*pDataLength +: pDataLength].
REQ-012 val_out  output  pChannels*pDataLength  registered delayed samples, same packing.
REQ-013 valid_out  output  1  one-cycle pulse: val_out was updated with real data this cycle.
REQ-014 primed  output  1  high while the line is in state RUN.
REQ-015 cur_delay  output  pPtrLength  active delay value.

Function
REQ-016 Storage: pMaxDelay entries, each pChannels*pDataLength wide; ptr wraps from cur_delay-1 to 0.
REQ-017 Each enabled step: val_out <= mem[ptr], mem[ptr] <= val_in, ptr advances (read-before-write).
REQ-018 Latency: val_out updated on enabled step k equals val_in of enabled step k-cur_delay, for every channel independently; cycles with enable low SHALL not count.
REQ-019 States: EMPTY (after reset/clear/load), FILL (counting steps), RUN (delay satisfied).
REQ-020 EMPTY -> FILL on first enabled step; FILL -> RUN on the enabled step where fill count reaches cur_delay; RUN persists until reset, clear or delay_load.
REQ-021 In EMPTY/FILL, val_out SHALL be driven to zero on enabled steps and valid_out SHALL stay low; memory content is not cleared.
REQ-022 In RUN, valid_out SHALL pulse high for exactly the cycle following each enabled step.
REQ-023 With enable low, val_out and ptr SHALL hold and valid_out SHALL be low.
REQ-024 clear: ptr <= 0, fill count <= 0, state <= EMPTY, val_out <= 0, valid_out <= 0; cur_delay unchanged.
REQ-025 delay_load: all effects of clear plus cur_delay <= delay_in, clamped: 0 -> 1, > pMaxDelay -> pMaxDelay.
REQ-026 Priority: reset > delay_load > clear > enable; an enabled sample coinciding with clear or delay_load SHALL be discarded.
REQ-027 cur_delay = 1: state SHALL reach RUN on the first enabled step, with valid_out high on the cycle after the second enabled step.

Reset
REQ-028 On reset: ptr = 0, fill count = 0, state = EMPTY, val_out = 0, valid_out = 0, primed = 0, cur_delay = pMaxDelay.
REQ-029 Reset asserted mid-operation SHALL take effect on the next edge regardless of enable, clear or delay_load.

Configuration
REQ-030 Macro DELAY_LINE_RUNTIME_DELAY_EN defined: delay_load/delay_in function per REQ-025.
REQ-031 Macro undefined: delay_load and delay_in SHALL be ignored (ports remain), and cur_delay SHALL be the constant pMaxDelay.

Verification
REQ-032 Reset, then cur_delay=32: enable 40 steps with ch0 = step index 0..39 -> valid_out first high after step 32; val_out ch0 = 0..7 on steps 32..39.
REQ-033 delay_in=5, delay_load, then feed ch0..3 = {n, n+100, n+200, n+300} -> each lane delayed exactly 5 steps, no lane crosstalk.
REQ-034 delay=3, enable toggling 1,0,0,1,... -> output indices match the enabled-step count only; valid_out never high after an idle cycle.
REQ-035 delay=4 in RUN, clear together with enable and val_in=0xAAAA -> sample dropped, primed=0, next 4 enabled steps output 0 and valid_out low.
REQ-036 delay_in=0 and delay_in=40 loaded -> cur_delay = 1 and 32 respectively; macro undefined -> cur_delay stays 32.
REQ-037 reset asserted in RUN simultaneously with delay_load and enable -> all REQ-028 values, cur_delay = 32.
